// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory arbiter: CPU controller and DMA/IO share one memory port, CPU favoured with DMA anti-starvation.
// Optional access timeout with sticky err flag is built when LC3_ARB_TIMEOUT_EN is defined.
module lc3_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, COMPLETE} state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t          state, state_nx;
    logic            owner_dma;
    logic [SW-1:0]   starve_cnt;
    logic            acc;
    logic            arb;
    logic            grant_dma;
    logic            timeout_hit;

    assign acc       = (state == CPU_ACC) || (state == DMA_ACC);
    assign arb       = (state == IDLE) && (cpu_req || dma_req);
    assign grant_dma = dma_req && (!cpu_req || (starve_cnt == STARVE_MAX));

`ifdef LC3_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!acc || mem_rdy) to_cnt <= '0;
            else                 to_cnt <= to_cnt + 1'b1;
            if (timeout_hit)     err_q  <= 1'b1;
        end
    end

    // Fires on the TIMEOUT-th access cycle that still has no mem_rdy.
    assign timeout_hit = acc && !mem_rdy && (to_cnt == TO_LAST);
    assign err         = err_q;
`else
    assign timeout_hit = 1'b0;
    // err stays 0; TIMEOUT is referenced so both builds share one parameter list.
    assign err         = 1'b0 && (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:             if (cpu_req || dma_req) state_nx = grant_dma ? DMA_ACC : CPU_ACC;
            CPU_ACC, DMA_ACC: if (mem_rdy || timeout_hit) state_nx = COMPLETE;
            COMPLETE:         state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_en   = 1'b0;
        cpu_done = 1'b0;
        dma_done = 1'b0;
        if (acc) mem_en = 1'b1;
        if (state == COMPLETE) begin
            cpu_done = !owner_dma;
            dma_done = owner_dma;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_dma  <= 1'b0;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            // Winner's command is frozen here; requester inputs are not looked at again until COMPLETE.
            if (arb) begin
                owner_dma <= grant_dma;
                mem_we    <= grant_dma ? dma_we    : cpu_we;
                mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
                mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
                if (grant_dma)
                    starve_cnt <= '0;
                else if (dma_req && (starve_cnt != STARVE_MAX))
                    starve_cnt <= starve_cnt + 1'b1;
            end
            if (acc && mem_rdy && !mem_we) begin
                if (owner_dma) dma_rdata <= mem_rdata;
                else           cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model. Define LC3_ARB_TIMEOUT_EN for the timeout build.
module tb_lc3_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SL = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_done, dma_done, mem_en, mem_we, mem_rdy, err;

    int n_vec  = 0;
    int n_fail = 0;

    lc3_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(SL),
        .TIMEOUT     (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_done (cpu_done),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata),
        .dma_done (dma_done),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Reference model: one access = arbitration, memory wait, one completion cycle.
    int            m_phase;   // 0 waiting for requests, 1 access in flight, 2 completion cycle
    bit            m_owner;   // 1 = DMA
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_cpu_rd, m_dma_rd;
    int            m_lose, m_wait;
    bit            m_err;
    bit            exp_cpu_done, exp_dma_done;

    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0; m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_cpu_rd = '0; m_dma_rd = '0; m_lose = 0; m_wait = 0; m_err = 0;
            exp_cpu_done = 0; exp_dma_done = 0;
            chk("rst_ctl", 64'({mem_en, mem_we, cpu_done, dma_done, err}), 64'(0));
            chk("rst_bus", 64'({mem_addr, mem_wdata}), 64'(0));
            chk("rst_rdata", 64'({cpu_rdata, dma_rdata}), 64'(0));
        end else begin
            exp_cpu_done = (m_phase == 2) && !m_owner;
            exp_dma_done = (m_phase == 2) && m_owner;
            chk("mem_en", 64'(mem_en), 64'(m_phase == 1));
            if (m_phase == 1)
                chk("mem_cmd", 64'({mem_we, mem_addr, mem_wdata}), 64'({m_we, m_addr, m_wdata}));
            chk("done", 64'({cpu_done, dma_done}), 64'({exp_cpu_done, exp_dma_done}));
            chk("rdata", 64'({cpu_rdata, dma_rdata}), 64'({m_cpu_rd, m_dma_rd}));
            chk("err", 64'(err), 64'(m_err));
            case (m_phase)
                0: if (cpu_req || dma_req) begin
                    m_owner = dma_req && (!cpu_req || m_lose == SL);
                    if (m_owner) m_lose = 0;
                    else if (dma_req && m_lose < SL) m_lose++;
                    m_we    = m_owner ? dma_we    : cpu_we;
                    m_addr  = m_owner ? dma_addr  : cpu_addr;
                    m_wdata = m_owner ? dma_wdata : cpu_wdata;
                    m_wait  = 0;
                    m_phase = 1;
                end
                1: if (mem_rdy) begin
                    if (!m_we) begin
                        if (m_owner) m_dma_rd = mem_rdata;
                        else         m_cpu_rd = mem_rdata;
                    end
                    m_phase = 2;
                end else begin
                    m_wait++;
`ifdef LC3_ARB_TIMEOUT_EN
                    if (m_wait == TO) begin
                        m_err   = 1;
                        m_phase = 2;
                    end
`endif
                end
                default: m_phase = 0;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int en_cnt, done_cnt, err_cnt;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        mem_rdy = 0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;

        // CPU read, memory ready immediately; mem_rdy in the idle cycle must be ignored
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000; cpu_wdata = 16'($urandom);
        mem_rdy = 1; mem_rdata = 16'h1234;
        step();
        chk("r21_en", 64'(mem_en), 64'(1));
        chk("r21_addr", 64'(mem_addr), 64'(16'h3000));
        chk("r21_nodone", 64'(cpu_done), 64'(0));
        step();
        chk("r21_done", 64'(cpu_done), 64'(1));
        chk("r21_rdata", 64'(cpu_rdata), 64'(16'h1234));
        chk("r21_en_off", 64'(mem_en), 64'(0));
        cpu_req = 0; mem_rdy = 0;
        step();
        chk("r21_pulse", 64'(cpu_done), 64'(0));

        // DMA read then DMA write with 3-cycle memory latency
        do_reset();
        dma_req = 1; dma_we = 0; dma_addr = 16'h0001; mem_rdy = 1; mem_rdata = 16'h5a5a;
        step(); step();
        chk("r23_rd_done", 64'(dma_done), 64'(1));
        chk("r23_rd_data", 64'(dma_rdata), 64'(16'h5a5a));
        dma_req = 0; mem_rdy = 0;
        step();
        dma_req = 1; dma_we = 1; dma_addr = 16'hfe00; dma_wdata = 16'h00aa; mem_rdata = 16'hbeef;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("r23_cmd", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'({2'b11, 16'hfe00, 16'h00aa}));
            chk("r23_wait_done", 64'(dma_done), 64'(0));
            dma_addr = 16'($urandom); dma_wdata = 16'($urandom); dma_we = 1'($urandom);
            if (i == 2) mem_rdy = 1;
            step();
        end
        chk("r23_wr_done", 64'(dma_done), 64'(1));
        chk("r23_rdata_kept", 64'(dma_rdata), 64'(16'h5a5a));
        dma_req = 0; mem_rdy = 0;
        step();

        // Reset in the middle of a CPU access
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1111;
        step();
        chk("r24_acc", 64'(mem_en), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("r24_async", 64'({mem_en, mem_addr, cpu_done}), 64'(0));
        step();
        rst = 1'b0; mem_rdy = 1; mem_rdata = 16'h4321;
        chk("r24_no_done", 64'(cpu_done), 64'(0));
        step();
        chk("r24_restart", 64'({mem_en, mem_addr}), 64'({1'b1, 16'h1111}));
        step();
        chk("r24_done", 64'({cpu_done, cpu_rdata}), 64'({1'b1, 16'h4321}));
        cpu_req = 0; mem_rdy = 0;
        step();

        // Both requesters saturating: every ninth grant goes to DMA
        do_reset();
        cpu_req = 1; dma_req = 1; cpu_we = 0; dma_we = 0; mem_rdy = 1;
        k = 0;
        for (int c = 0; c < 300 && k < 27; c++) begin
            mem_rdata = 16'($urandom);
            step();
            if (dma_done) begin
                chk("starve_dma_slot", 64'(k % 9), 64'(8));
                k++;
            end else if (cpu_done) begin
                chk("starve_cpu_slot", 64'(k % 9 == 8), 64'(0));
                k++;
            end
        end
        chk("starve_grants", 64'(k), 64'(27));
        cpu_req = 0; dma_req = 0; mem_rdy = 0;
        step();

`ifdef LC3_ARB_TIMEOUT_EN
        // Memory never answers: timeout after TO access cycles, err sticky until reset
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2222;
        step();
        en_cnt = 0; done_cnt = 0;
        for (int i = 0; i < TO; i++) begin
            en_cnt += int'(mem_en);
            done_cnt += int'(cpu_done);
            step();
        end
        chk("to_en_cycles", 64'(en_cnt), 64'(TO));
        chk("to_early_done", 64'(done_cnt), 64'(0));
        chk("to_done_err", 64'({cpu_done, err, mem_en}), 64'(3'b110));
        cpu_req = 0;
        step();
        cpu_req = 1; mem_rdy = 1; mem_rdata = 16'h7777;
        step(); step();
        chk("to_err_sticky", 64'({cpu_done, err, cpu_rdata}), 64'({2'b11, 16'h7777}));
        cpu_req = 0; mem_rdy = 0;
        do_reset();
        chk("to_err_clear", 64'(err), 64'(0));
`else
        // Memory withheld for 100 cycles: access simply waits
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2222;
        step();
        en_cnt = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            en_cnt += int'(mem_en);
            done_cnt += int'(cpu_done);
            err_cnt += int'(err);
            step();
        end
        chk("wait_en_cycles", 64'(en_cnt), 64'(100));
        chk("wait_no_done", 64'(done_cnt), 64'(0));
        chk("wait_no_err", 64'(err_cnt), 64'(0));
        mem_rdy = 1; mem_rdata = 16'h7777;
        step();
        chk("wait_done", 64'({cpu_done, cpu_rdata, err}), 64'({1'b1, 16'h7777, 1'b0}));
        cpu_req = 0; mem_rdy = 0;
        step();
`endif

        // Randomized traffic: requesters hold req until their completion pulse
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
            mem_rdy = ($urandom_range(3) != 0); mem_rdata = 16'($urandom);
            if (exp_cpu_done) cpu_req = 0;
            else if (!cpu_req) cpu_req = ($urandom_range(2) == 0);
            if (exp_dma_done) dma_req = 0;
            else if (!dma_req) dma_req = ($urandom_range(2) == 0);
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 0; cpu_req = 0; dma_req = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, consecutive DMA-losing arbitrations before DMA gets forced priority.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum cycles to wait for mem_rdy (used only under LC3_ARB_TIMEOUT_EN).
REQ-005 SHALL have ports, in this order:
 clk in 1 sole clock, rising edge; rst in 1 asynchronous, active-high reset
 cpu_req in 1 LC-3 controller access request; cpu_we in 1 write when 1
 cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_rdata out DATA_W; cpu_done out 1 one-cycle completion pulse
 dma_req in 1 DMA/IO access request; dma_we in 1; dma_addr in ADDR_W; dma_wdata in DATA_W
 dma_rdata out DATA_W; dma_done out 1 one-cycle completion pulse
 mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W
 mem_rdata in DATA_W; mem_rdy in 1 memory completes access this cycle
 err out 1 sticky timeout flag (tied 0 without LC3_ARB_TIMEOUT_EN)

Function
REQ-006 SHALL implement FSM states IDLE, CPU_ACC, DMA_ACC, COMPLETE.
REQ-007 IDLE: both requests -> CPU_ACC unless starve_cnt == STARVE_LIMIT, then DMA_ACC; one request -> that owner; none -> stay.
REQ-008 SHALL latch winner's we/addr/wdata on the IDLE exit edge; requester inputs are ignored after latching.
REQ-009 In CPU_ACC/DMA_ACC SHALL drive mem_en=1 with latched mem_we/mem_addr/mem_wdata; mem_en=0 in every other state.
REQ-010 On mem_rdy=1 in an ACC state SHALL capture mem_rdata into winner's rdata register (reads only) and go to COMPLETE.
REQ-011 COMPLETE SHALL last exactly one cycle, pulse winner's done, and return to IDLE; minimum request-to-done latency is 2 cycles (mem_rdy same cycle as mem_en).
REQ-012 Requester holds req high until its done; req asserted during COMPLETE is rearbitrated in the following IDLE cycle.
REQ-013 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, when CPU wins while dma_req=1; clear to 0 when DMA wins.
REQ-014 cpu_rdata/dma_rdata SHALL hold last captured value until the next read completion for that owner; writes leave them unchanged.
REQ-015 cpu_done and dma_done SHALL never assert in the same cycle.
REQ-016 mem_rdy outside ACC states SHALL be ignored.

Reset
REQ-017 On rst=1 SHALL immediately (asynchronously) enter IDLE and clear mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata, cpu_done, dma_done, starve_cnt, err, timeout counter to 0.
REQ-018 Reset mid-access SHALL abandon it with no done pulse; arbitration resumes on the first clk edge after rst deasserts.

Configuration
REQ-019 Macro LC3_ARB_TIMEOUT_EN defined: ACC-state cycle counter; if TIMEOUT cycles elapse without mem_rdy, SHALL set err=1 (sticky until rst), pulse winner's done with rdata unchanged, go to COMPLETE.
REQ-020 Macro undefined: SHALL wait indefinitely in ACC for mem_rdy; no counter logic; err tied 0.

Verification
REQ-021 Reset then cpu_req=1, cpu_we=0, cpu_addr=0x3000, mem_rdy next cycle with mem_rdata=0x1234 -> mem_en 1 cycle, cpu_rdata=0x1234, cpu_done pulse 2 cycles after req.
REQ-022 cpu_req and dma_req both held high continuously, mem_rdy always 1 -> 8 CPU grants then 1 DMA grant, repeating; starve_cnt returns to 0 after DMA grant.
REQ-023 dma_req=1, dma_we=1, dma_addr=0xFE00, dma_wdata=0x00AA, mem_rdy delayed 3 cycles -> mem_we=1, mem_addr/mem_wdata stable all 3 cycles, dma_done pulse, dma_rdata unchanged.
REQ-024 rst pulsed while in CPU_ACC -> outputs zero same cycle, no cpu_done, next cpu_req restarts access normally.
REQ-025 With LC3_ARB_TIMEOUT_EN, TIMEOUT=16, mem_rdy never asserted -> err=1 and cpu_done after 16 ACC cycles; err remains 1 across later accesses until rst.
REQ-026 Without LC3_ARB_TIMEOUT_EN, mem_rdy withheld 100 cycles -> mem_en stays 1, err=0, done only after mem_rdy.
